// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master slice.
package spi_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

  // Only mode 0 is implemented; kept for future mode support.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: counts while enabled, emits edge strobes and registered sclk.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclk_en,
  output logic tick,
  output logic rise_stb,
  output logic fall_stb,
  output logic sclk
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    tick      = en && (div_cnt_q == CW'(CLK_DIV - 1));
    rise_stb  = tick && sclk_en && !sclk_q;
    fall_stb  = tick && sclk_en && sclk_q;
    sclk_d    = sclk_q ^ (rise_stb | fall_stb);
    div_cnt_d = div_cnt_q + CW'(1);
    if (!en || tick) div_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sclk_q    <= SPI_CPOL;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: FSM plus shift registers, SCLK from spi_clk_gen.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W + 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic              cg_en, sclk_en;
  logic              tick, rise_stb, fall_stb;

  // The final low half-period runs in XFER with toggling disabled.
  assign cg_en   = (state_q != IDLE);
  assign sclk_en = (state_q == SETUP) ||
                   ((state_q == XFER) && (bit_cnt_q != BW'(DATA_W)));

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (cg_en),
    .sclk_en  (sclk_en),
    .tick     (tick),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .sclk     (sclk)
  );

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SETUP;
          tx_sr_d   = tx_data;
          mosi_d    = tx_data[DATA_W-1];
          bit_cnt_d = '0;
          ss_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      SETUP: begin
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (fall_stb) begin
          rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q != BW'(DATA_W - 1)) begin
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_sr_q[DATA_W-2];
          end
        end else if (tick && (bit_cnt_q == BW'(DATA_W))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = GAP;
          ss_d      = 1'b1;
          rx_data_d = rx_sr_q;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: default instance plus a DATA_W=16 / CLK_DIV=2 instance.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;

  logic       start;
  logic [7:0] tx_data;
  logic       busy, done, sclk, ss, mosi, miso;
  logic [7:0] rx_data;

  logic        start_b;
  logic [15:0] tx_b;
  logic        busy_b, done_b, sclk_b, ss_b, mosi_b;
  logic [15:0] rx_b;

  logic       slave_mode;
  logic       miso_slv;
  logic [7:0] slv_sr;
  logic [7:0] slv_word;

  int n_chk  = 0;
  int n_pass = 0;

  logic       ss_h   [0:255];
  logic       sclk_h [0:255];
  logic       mosi_h [0:255];
  logic       done_h [0:255];
  logic       busy_h [0:255];
  logic [7:0] rx_h   [0:255];

  always #5 clk = ~clk;

  spi_master u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .ss      (ss),
    .mosi    (mosi),
    .miso    (miso)
  );

  spi_master #(
    .DATA_W  (16),
    .CLK_DIV (2)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .start   (start_b),
    .tx_data (tx_b),
    .busy    (busy_b),
    .done    (done_b),
    .rx_data (rx_b),
    .sclk    (sclk_b),
    .ss      (ss_b),
    .mosi    (mosi_b),
    .miso    (mosi_b)
  );

  assign miso = slave_mode ? miso_slv : mosi;

  // Slave shifts its word out MSB first, changing on sclk rise.
  always @(posedge sclk or negedge ss) begin
    if (sclk) begin
      miso_slv = slv_sr[7];
      slv_sr   = {slv_sr[6:0], 1'b0};
    end else begin
      slv_sr = slv_word;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a transfer, then record DUT A for ncyc cycles (index n = T+n).
  task automatic run(input logic [7:0] tx, input int ncyc,
                     input int pulse_at, input int rst_at,
                     input bit hold, input logic [7:0] tx2);
    tx_data = tx;
    start   = 1'b1;
    step();
    for (int n = 1; n <= ncyc; n++) begin
      ss_h[n]   = ss;
      sclk_h[n] = sclk;
      mosi_h[n] = mosi;
      done_h[n] = done;
      busy_h[n] = busy;
      rx_h[n]   = rx_data;
      start     = hold;
      if (n == 1) tx_data = tx2;
      if (n == pulse_at) begin
        start   = 1'b1;
        tx_data = 8'hFF;
      end
      rst = (n == rst_at);
      step();
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  function automatic int cnt_low(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (!ss_h[i]) c++;
    return c;
  endfunction

  function automatic int cnt_set(input int lo, input int hi, input int sel);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (sel == 0 && done_h[i]) c++;
      if (sel == 1 && busy_h[i]) c++;
      if (sel == 2 && mosi_h[i]) c++;
      if (sel == 3 && ss_h[i]) c++;
      if (sel == 4 && i > lo && sclk_h[i] && !sclk_h[i-1]) c++;
    end
    return c;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      step();
      k++;
    end
    check("idle_timeout", 32'(k < 300), 32'd1);
  endtask

  initial begin
    logic [7:0]  mw;
    logic        pb;
    int          rises, bad_gap, last_r, done_at, k;
    rst        = 1'b1;
    start      = 1'b0;
    tx_data    = '0;
    start_b    = 1'b0;
    tx_b       = '0;
    slave_mode = 1'b0;
    slv_word   = 8'h00;
    slv_sr     = 8'h00;
    miso_slv   = 1'b0;
    repeat (3) step();
    check("rst_ss",   32'(ss),      32'd1);
    check("rst_sclk", 32'(sclk),    32'd0);
    check("rst_mosi", 32'(mosi),    32'd0);
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_done", 32'(done),    32'd0);
    check("rst_rx",   32'(rx_data), 32'd0);
    rst = 1'b0;
    step();

    // 1: loopback A5
    run(8'hA5, 80, 0, 0, 1'b0, 8'hA5);
    check("t1_ss_first", 32'(ss_h[1]),     32'd0);
    check("t1_ss_low",   32'(cnt_low(1, 80)), 32'd72);
    check("t1_ss_back",  32'(ss_h[73]),    32'd1);
    check("t1_sclk_n",   32'(cnt_set(1, 80, 4)), 32'd8);
    check("t1_done_at",  32'(done_h[73]),  32'd1);
    check("t1_done_n",   32'(cnt_set(1, 80, 0)), 32'd1);
    check("t1_rx",       32'(rx_h[73]),    32'hA5);
    check("t1_busy_n",   32'(cnt_set(1, 80, 1)), 32'd76);
    check("t1_busy_off", 32'(busy_h[77]),  32'd0);

    // 2: slave drives 3C, tx 00
    slave_mode = 1'b1;
    slv_word   = 8'h3C;
    run(8'h00, 80, 0, 0, 1'b0, 8'h00);
    slave_mode = 1'b0;
    check("t2_rx",     32'(rx_h[80]), 32'h3C);
    check("t2_mosi_0", 32'(cnt_set(1, 80, 2)), 32'd0);

    // 3: second start at T+20 ignored
    run(8'h5A, 80, 20, 0, 1'b0, 8'h5A);
    mw = '0;
    for (int i = 0; i < 8; i++) begin
      pb = mosi_h[1 + 4 * (1 + 2 * i)];
      mw = {mw[6:0], pb};
    end
    check("t3_mosi_seq", 32'(mw),        32'h5A);
    check("t3_done_n",   32'(cnt_set(1, 80, 0)), 32'd1);
    check("t3_rx",       32'(rx_h[80]),  32'h5A);

    // 4: reset mid-transfer at T+30
    run(8'hC3, 90, 0, 30, 1'b0, 8'hC3);
    check("t4_ss",     32'(ss_h[31]),   32'd1);
    check("t4_sclk",   32'(sclk_h[31]), 32'd0);
    check("t4_busy",   32'(busy_h[31]), 32'd0);
    check("t4_mosi",   32'(mosi_h[31]), 32'd0);
    check("t4_rx",     32'(rx_h[31]),   32'd0);
    check("t4_no_done", 32'(cnt_set(1, 90, 0)), 32'd0);

    // 5: start held, 81 then 7E
    run(8'h81, 153, 0, 0, 1'b1, 8'h7E);
    check("t5_ss_pre",  32'(ss_h[72]),  32'd0);
    check("t5_ss_high", 32'(cnt_set(73, 77, 3)), 32'd5);
    check("t5_ss_next", 32'(ss_h[78]),  32'd0);
    check("t5_rx1",     32'(rx_h[73]),  32'h81);
    check("t5_done2",   32'(done_h[150]), 32'd1);
    check("t5_rx2",     32'(rx_h[150]), 32'h7E);
    wait_idle();

    // 6: DATA_W=16, CLK_DIV=2 loopback BEEF
    tx_b    = 16'hBEEF;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    rises   = 0;
    bad_gap = 0;
    last_r  = 0;
    done_at = 0;
    pb      = sclk_b;
    for (int n = 1; n <= 80; n++) begin
      if (sclk_b && !pb) begin
        if (rises > 0 && n - last_r != 4) bad_gap++;
        rises++;
        last_r = n;
      end
      if (done_b && done_at == 0) done_at = n;
      if (n == 69) check("t6_rx", 32'(rx_b), 32'hBEEF);
      pb = sclk_b;
      step();
    end
    check("t6_sclk_n", 32'(rises),   32'd16);
    check("t6_period", 32'(bad_gap), 32'd0);
    check("t6_done",   32'(done_at), 32'd69);
    k = 0;
    while (busy_b && k < 50) begin
      step();
      k++;
    end
    check("t6_idle", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
